// File: rtl/grey_seq_pkg.sv
// Shared types and constants for the greyscale frame sequencer.
package grey_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    localparam int COORD_W      = 11;
    localparam int PIX_W        = 12;
    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 960;

endpackage

// File: rtl/pix_coord_cnt.sv
// Raster X/Y counter: x/y/last describe the pixel being accepted this cycle,
// taking a same-cycle clear into account so the first pixel reads (0,0).
import grey_seq_pkg::*;

module pix_coord_cnt #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [COORD_W-1:0] x_nxt_s;
    logic [COORD_W-1:0] y_nxt_s;

    // Current coordinate and raster-order successor.
    always_comb begin
        x       = clr ? {COORD_W{1'b0}} : x_r;
        y       = clr ? {COORD_W{1'b0}} : y_r;
        last    = (x == X_LAST) && (y == Y_LAST);
        x_nxt_s = x;
        y_nxt_s = y;
        if (adv) begin
            if (x == X_LAST) begin
                x_nxt_s = {COORD_W{1'b0}};
                y_nxt_s = (y == Y_LAST) ? {COORD_W{1'b0}} : y + {{(COORD_W-1){1'b0}}, 1'b1};
            end else begin
                x_nxt_s = x + {{(COORD_W-1){1'b0}}, 1'b1};
                y_nxt_s = y;
            end
        end else begin
            x_nxt_s = x;
            y_nxt_s = y;
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= {COORD_W{1'b0}};
            y_r <= {COORD_W{1'b0}};
        end else begin
            x_r <= x_nxt_s;
            y_r <= y_nxt_s;
        end
    end

endmodule

// File: rtl/greyscale_seq.sv
// Frame sequencer feeding to_greyscale: admits only whole frames.
// Optional frame counter port enabled by GREY_SEQ_FRAME_CNT_EN.
import grey_seq_pkg::*;

module greyscale_seq #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iSTART,
    input  logic               iSTOP,
    input  logic               iFVAL,
    input  logic               iDVAL,
    input  logic [PIX_W-1:0]   iDATA,
    output logic [PIX_W-1:0]   oDATA,
    output logic               oDVAL,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont,
    output logic               oBUSY,
    output logic               oFRAME_DONE,
    output logic               oFRAME_ERR
`ifdef GREY_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0]        oFRAME_CNT
`endif
);

    seq_state_t         state_r;
    seq_state_t         state_nxt_s;
    logic               fval_r;
    logic               stop_pend_r;
    logic               stop_pend_nxt_s;
    logic               fs_s;
    logic               fall_s;
    logic               pix_valid_s;
    logic               clr_s;
    logic               accept_s;
    logic               done_s;
    logic               err_s;
    logic               last_s;
    logic [COORD_W-1:0] x_s;
    logic [COORD_W-1:0] y_s;

    assign fs_s        = iFVAL & ~fval_r;
    assign fall_s      = fval_r & ~iFVAL;
    assign pix_valid_s = iDVAL & iFVAL;
    // Locking onto a frame start: a pixel in that same cycle is (0,0).
    assign clr_s       = (state_r == ARM) & fs_s & ~iSTOP;
    assign accept_s    = pix_valid_s & ((state_r == RUN) | clr_s);

    pix_coord_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_coord (
        .clk   (iCLK),
        .rst_n (iRST),
        .clr   (clr_s),
        .adv   (accept_s),
        .x     (x_s),
        .y     (y_s),
        .last  (last_s)
    );

    // State register, frame-valid history and pending stop.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_r     <= IDLE;
            fval_r      <= 1'b1;
            stop_pend_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            fval_r      <= iFVAL;
            stop_pend_r <= stop_pend_nxt_s;
        end
    end

    // Next-state logic and frame status.
    always_comb begin
        state_nxt_s     = state_r;
        stop_pend_nxt_s = stop_pend_r;
        done_s          = 1'b0;
        err_s           = 1'b0;
        case (state_r)
            IDLE: begin
                stop_pend_nxt_s = 1'b0;
                if (iSTART & ~iSTOP) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM: begin
                if (iSTOP) begin
                    state_nxt_s     = IDLE;
                    stop_pend_nxt_s = 1'b0;
                end else if (fs_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = ARM;
                end
            end
            RUN: begin
                stop_pend_nxt_s = stop_pend_r | iSTOP;
                if (pix_valid_s & last_s) begin
                    done_s          = 1'b1;
                    state_nxt_s     = (stop_pend_r | iSTOP) ? IDLE : ARM;
                    stop_pend_nxt_s = 1'b0;
                end else if (fall_s) begin
                    err_s           = 1'b1;
                    state_nxt_s     = (stop_pend_r | iSTOP) ? IDLE : ARM;
                    stop_pend_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                stop_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; pixel and coordinates hold between accepted pixels.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA       <= {PIX_W{1'b0}};
            oDVAL       <= 1'b0;
            oX_Cont     <= {COORD_W{1'b0}};
            oY_Cont     <= {COORD_W{1'b0}};
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oFRAME_ERR  <= 1'b0;
        end else begin
            oDVAL       <= accept_s;
            oBUSY       <= (state_r != IDLE);
            oFRAME_DONE <= done_s;
            oFRAME_ERR  <= err_s;
            if (accept_s) begin
                oDATA   <= iDATA;
                oX_Cont <= x_s;
                oY_Cont <= y_s;
            end else begin
                oDATA   <= oDATA;
                oX_Cont <= oX_Cont;
                oY_Cont <= oY_Cont;
            end
        end
    end

`ifdef GREY_SEQ_FRAME_CNT_EN
    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oFRAME_CNT <= 16'h0000;
        end else if (done_s) begin
            oFRAME_CNT <= oFRAME_CNT + 16'h0001;
        end else begin
            oFRAME_CNT <= oFRAME_CNT;
        end
    end
`endif

endmodule

// File: tb/tb_greyscale_seq.sv
// Directed bench for greyscale_seq with a 4x2 frame.
module tb_greyscale_seq;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iSTART = 1'b0;
    logic        iSTOP = 1'b0;
    logic        iFVAL = 1'b0;
    logic        iDVAL = 1'b0;
    logic [11:0] iDATA = 12'h000;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic        oBUSY;
    logic        oFRAME_DONE;
    logic        oFRAME_ERR;
`ifdef GREY_SEQ_FRAME_CNT_EN
    logic [15:0] oFRAME_CNT;
`endif

    int n_total = 0;
    int n_pass  = 0;

    greyscale_seq #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iSTART      (iSTART),
        .iSTOP       (iSTOP),
        .iFVAL       (iFVAL),
        .iDVAL       (iDVAL),
        .iDATA       (iDATA),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oBUSY       (oBUSY),
        .oFRAME_DONE (oFRAME_DONE),
        .oFRAME_ERR  (oFRAME_ERR)
`ifdef GREY_SEQ_FRAME_CNT_EN
        ,
        .oFRAME_CNT  (oFRAME_CNT)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        st, sp, fv, dv;
        logic [11:0] d;
        logic        e_dv;
        int          e_x, e_y;
        logic [11:0] e_d;
        logic        e_done, e_err, e_busy;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic st, sp, fv, dv, input logic [11:0] d,
                                input logic e_dv, input int e_x, e_y,
                                input logic [11:0] e_d, input logic e_done, e_err, e_busy);
        vec_t v;
        v.st = st; v.sp = sp; v.fv = fv; v.dv = dv; v.d = d;
        v.e_dv = e_dv; v.e_x = e_x; v.e_y = e_y; v.e_d = e_d;
        v.e_done = e_done; v.e_err = e_err; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and sample the registered result after the edge.
    task automatic cyc(input logic st, sp, fv, dv, input logic [11:0] d);
        iSTART = st; iSTOP = sp; iFVAL = fv; iDVAL = dv; iDATA = d;
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dval"}, int'(oDVAL), 0);
        chk({tag, "_data"}, int'(oDATA), 0);
        chk({tag, "_x"}, int'(oX_Cont), 0);
        chk({tag, "_y"}, int'(oY_Cont), 0);
        chk({tag, "_busy"}, int'(oBUSY), 0);
        chk({tag, "_done"}, int'(oFRAME_DONE), 0);
        chk({tag, "_err"}, int'(oFRAME_ERR), 0);
`ifdef GREY_SEQ_FRAME_CNT_EN
        chk({tag, "_cnt"}, int'(oFRAME_CNT), 0);
`endif
    endtask

    task automatic chk_cnt(input string name, input int exp);
`ifdef GREY_SEQ_FRAME_CNT_EN
        chk(name, int'(oFRAME_CNT), exp);
`else
        if (exp < 0) $display("unexpected count %0d for %s", exp, name);
`endif
    endtask

    // Drive fs plus n back-to-back pixels, then one frame-valid-low cycle.
    task automatic frame(input string tag, input int n, input int stop_at,
                         input logic cap, input logic st);
        for (int i = 0; i < n; i++) begin
            cyc(st, (i == stop_at), 1'b1, 1'b1, 12'(i + 1));
            if (cap) begin
                chk({tag, "_dval"}, int'(oDVAL), 1);
                chk({tag, "_x"}, int'(oX_Cont), i % 4);
                chk({tag, "_y"}, int'(oY_Cont), i / 4);
                chk({tag, "_data"}, int'(oDATA), i + 1);
                chk({tag, "_done"}, int'(oFRAME_DONE), (i == 7) ? 1 : 0);
            end else begin
                chk({tag, "_nodval"}, int'(oDVAL), 0);
                chk({tag, "_nodone"}, int'(oFRAME_DONE), 0);
            end
        end
        cyc(st, 1'b0, 1'b0, 1'b0, 12'h000);
        chk({tag, "_tail_err"}, int'(oFRAME_ERR), (cap && n < 8) ? 1 : 0);
        chk({tag, "_tail_done"}, int'(oFRAME_DONE), 0);
        chk({tag, "_tail_dval"}, int'(oDVAL), 0);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 1);
        tbl[2]  = mk(0, 0, 1, 1, 12'h001, 1, 0, 0, 12'h001, 0, 0, 1);
        tbl[3]  = mk(0, 0, 1, 1, 12'h002, 1, 1, 0, 12'h002, 0, 0, 1);
        tbl[4]  = mk(0, 0, 1, 1, 12'h003, 1, 2, 0, 12'h003, 0, 0, 1);
        tbl[5]  = mk(0, 0, 1, 1, 12'h004, 1, 3, 0, 12'h004, 0, 0, 1);
        tbl[6]  = mk(0, 0, 1, 0, 12'h000, 0, 3, 0, 12'h000, 0, 0, 1);
        tbl[7]  = mk(0, 0, 1, 1, 12'h005, 1, 0, 1, 12'h005, 0, 0, 1);
        tbl[8]  = mk(0, 0, 1, 1, 12'h006, 1, 1, 1, 12'h006, 0, 0, 1);
        tbl[9]  = mk(0, 0, 1, 1, 12'h007, 1, 2, 1, 12'h007, 0, 0, 1);
        tbl[10] = mk(0, 0, 1, 1, 12'h008, 1, 3, 1, 12'h008, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 12'h000, 0, 3, 1, 12'h000, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 1, 12'h009, 0, 3, 1, 12'h000, 0, 0, 1);

        repeat (3) @(posedge iCLK);
        #1;
        chk_all_zero("reset");
        iRST = 1'b1;

        // Normal frame
        for (int r = 0; r < 13; r++) begin
            cyc(tbl[r].st, tbl[r].sp, tbl[r].fv, tbl[r].dv, tbl[r].d);
            chk($sformatf("norm%0d_dval", r), int'(oDVAL), int'(tbl[r].e_dv));
            chk($sformatf("norm%0d_x", r), int'(oX_Cont), tbl[r].e_x);
            chk($sformatf("norm%0d_y", r), int'(oY_Cont), tbl[r].e_y);
            chk($sformatf("norm%0d_done", r), int'(oFRAME_DONE), int'(tbl[r].e_done));
            chk($sformatf("norm%0d_err", r), int'(oFRAME_ERR), int'(tbl[r].e_err));
            chk($sformatf("norm%0d_busy", r), int'(oBUSY), int'(tbl[r].e_busy));
            if (tbl[r].e_dv) chk($sformatf("norm%0d_data", r), int'(oDATA), int'(tbl[r].e_d));
        end
        chk_cnt("norm_cnt", 1);

        // Short frame, then a full frame from (0,0)
        frame("short", 5, -1, 1'b1, 1'b0);
        cyc(0, 0, 0, 0, 12'h000);
        chk("short_err_once", int'(oFRAME_ERR), 0);
        chk("short_busy_arm", int'(oBUSY), 1);
        chk_cnt("short_cnt", 1);
        frame("after_short", 8, -1, 1'b1, 1'b0);
        chk_cnt("after_short_cnt", 2);
        chk("after_short_busy", int'(oBUSY), 1);

        // Mid-frame arm: stop in ARM, frame already running when start rises
        cyc(0, 1, 0, 0, 12'h000);
        cyc(0, 0, 0, 0, 12'h000);
        chk("midarm_idle_busy", int'(oBUSY), 0);
        cyc(0, 0, 1, 1, 12'h011);
        cyc(1, 0, 1, 1, 12'h012);
        chk("midarm_nodval0", int'(oDVAL), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 12'(8'h13 + i));
            chk($sformatf("midarm_nodval%0d", i + 1), int'(oDVAL), 0);
        end
        cyc(0, 0, 0, 0, 12'h000);
        chk("midarm_busy", int'(oBUSY), 1);
        chk("midarm_noerr", int'(oFRAME_ERR), 0);
        frame("midarm", 8, -1, 1'b1, 1'b0);

        // Stop mid-frame: frame completes, then IDLE ignores the next frame
        frame("stop", 8, 3, 1'b1, 1'b0);
        chk("stop_busy", int'(oBUSY), 0);
        frame("stop_ignored", 8, -1, 1'b0, 1'b0);
        chk("stop_ignored_busy", int'(oBUSY), 0);

        // Start/stop contention
        cyc(1, 1, 0, 0, 12'h000);
        cyc(0, 0, 0, 0, 12'h000);
        chk("cont_idle_busy", int'(oBUSY), 0);
        cyc(1, 0, 0, 0, 12'h000);
        cyc(0, 0, 0, 0, 12'h000);
        chk("cont_arm_busy", int'(oBUSY), 1);
        cyc(0, 1, 1, 1, 12'h0AA);
        chk("cont_fs_stop_dval", int'(oDVAL), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 12'h0AB);
            chk($sformatf("cont_nodval%0d", i), int'(oDVAL), 0);
        end
        cyc(0, 0, 0, 0, 12'h000);
        chk("cont_end_busy", int'(oBUSY), 0);

        // Reset at pixel 6 with start held
        cyc(1, 0, 0, 0, 12'h000);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 1, 12'(i + 1));
            chk($sformatf("rst_pre_x%0d", i), int'(oX_Cont), i % 4);
            chk($sformatf("rst_pre_y%0d", i), int'(oY_Cont), i / 4);
        end
        iSTART = 1'b1; iFVAL = 1'b1; iDVAL = 1'b1; iDATA = 12'h006;
        iRST = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        cyc(1, 0, 1, 1, 12'h007);
        chk("rst_post_dval7", int'(oDVAL), 0);
        cyc(1, 0, 1, 1, 12'h008);
        chk("rst_post_dval8", int'(oDVAL), 0);
        cyc(1, 0, 0, 0, 12'h000);
        chk("rst_post_noerr", int'(oFRAME_ERR), 0);
        frame("rst_next", 8, -1, 1'b1, 1'b1);
        chk_cnt("rst_next_cnt", 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/greyscale_seq.md
# greyscale_seq

Frame sequencer in front of `to_greyscale`. It arms on software start and locks onto the next sensor frame boundary. For each accepted raw Bayer pixel it produces the aligned `iX_Cont`/`iY_Cont` coordinates and gated valid that `to_greyscale` consumes. It guarantees only whole frames enter the greyscale datapath, and reports frame completion and short-frame errors.

## Interface
Parameters:
- `H_ACTIVE`, default 1280: active pixels per line. Valid range 2..2047, even.
- `V_ACTIVE`, default 960: active lines per frame. Valid range 2..2047, even.

Ports:
- `iCLK` input, 1 bit: single clock, all logic on the rising edge.
- `iRST` input, 1 bit: asynchronous, active-low reset.
- `iSTART` input, 1 bit: level; request capture.
- `iSTOP` input, 1 bit: level; request stop at the end of the current frame.
- `iFVAL` input, 1 bit: sensor frame valid.
- `iDVAL` input, 1 bit: raw pixel valid.
- `iDATA` input, 12 bits: raw Bayer pixel.
- `oDATA` output, 12 bits: registered pixel, routed to `to_greyscale.iDATA`.
- `oDVAL` output, 1 bit: gated valid, routed to `to_greyscale.iDVAL`.
- `oX_Cont` output, 11 bits: column of `oDATA`.
- `oY_Cont` output, 11 bits: line of `oDATA`.
- `oBUSY` output, 1 bit: high in ARM or RUN.
- `oFRAME_DONE` output, 1 bit: one-cycle pulse.
- `oFRAME_ERR` output, 1 bit: one-cycle pulse on a short frame.
- `oFRAME_CNT` output, 16 bits: completed frames. Present only with `GREY_SEQ_FRAME_CNT_EN`.

## Operation
- **States:** IDLE, ARM, RUN. Reset state is IDLE.
- **Frame-start edge detection:** `fval_q` registers `iFVAL` and resets to 1. A frame already in progress at reset release is therefore never captured. Frame start (`fs`) is `iFVAL & ~fval_q`.
- **IDLE:**
  - `iSTART & ~iSTOP` → ARM.
  - Otherwise stay in IDLE. If both are high, stop wins.
- **ARM:**
  - `iSTOP` → IDLE. Stop wins over `fs` in the same cycle.
  - Otherwise `fs` → RUN, and coordinates clear to (0,0).
  - A pixel with `iDVAL` in the `fs` cycle is accepted as (0,0).
- **RUN, pixel acceptance:**
  - A pixel is accepted when `iDVAL & iFVAL`. `iDVAL` while `iFVAL` is low is ignored.
  - The first pixel is the one in the `fs` cycle (see ARM); it is accepted as (0,0).
  - Each subsequent accepted pixel advances X by 1.
  - At X = `H_ACTIVE`-1, X wraps to 0 and Y increments.
- **RUN, stop request:** `iSTOP` sets `stop_pend`, which is cleared on entry to IDLE. The current frame always completes.
- **RUN, frame end:** the last pixel is an accepted pixel at (`H_ACTIVE`-1, `V_ACTIVE`-1). On it:
  - pulse `oFRAME_DONE`;
  - go to IDLE if `stop_pend` or `iSTOP` is set, else go to ARM.
  - Pixels after the last pixel and before the next `fs` are dropped.
- **RUN, short frame:** `iFVAL` falls (`fval_q & ~iFVAL`) before the last pixel. Then:
  - pulse `oFRAME_ERR`; there is no `oFRAME_DONE`;
  - go to IDLE if `stop_pend` or `iSTOP` is set, else go to ARM.
- **`iSTART` outside IDLE:** ignored.
- **Counter width:** X and Y are 11 bits and never exceed the parameter limits. Arithmetic is unsigned; there is no saturation.

## Timing
- **Latency:** all outputs are registered. `oDATA`, `oDVAL`, `oX_Cont` and `oY_Cont` lag the accepting input cycle by exactly 1 cycle and are mutually aligned.
- **Coordinates on a valid pixel:** `oX_Cont`/`oY_Cont` show the coordinate of the pixel in the same output cycle, so the first pixel of a frame appears with (0,0).
- **Coordinates between pixels:** coordinates hold when `oDVAL` = 0.
- **Status pulses:** `oFRAME_DONE` asserts in the same output cycle as the last pixel's `oDVAL`. `oFRAME_ERR` asserts the cycle after the `iFVAL` fall is sampled.
- **`oBUSY`:** registered from the state; it reflects the state one cycle after each transition.
- **Reset values:**
  - `oDATA` = 0, `oDVAL` = 0, `oX_Cont` = 0, `oY_Cont` = 0;
  - `oBUSY` = 0, `oFRAME_DONE` = 0, `oFRAME_ERR` = 0, `oFRAME_CNT` = 0;
  - internal state IDLE, `fval_q` = 1, `stop_pend` = 0.
- **Reset mid-frame:** asserting `iRST` mid-frame immediately zeroes all outputs. After release the block is in IDLE and ignores the remainder of that frame, even if `iSTART` is held, because `fval_q` resets to 1.

## Configuration
- **`GREY_SEQ_FRAME_CNT_EN` defined:** port `oFRAME_CNT` exists. It increments by 1 in the `oFRAME_DONE` output cycle and wraps from 16'hFFFF to 0. Short frames do not count.
- **Macro undefined:** the port and the counter register are absent. All other behaviour is identical.

## Structure
- **Package `grey_seq_pkg`:**
  - `seq_state_t` enum {IDLE, ARM, RUN};
  - `COORD_W` = 11, `PIX_W` = 12;
  - default `H_ACTIVE`/`V_ACTIVE` constants.
- **Sub-module `pix_coord_cnt`:**
  - Function: X/Y counter with a clear input, an advance input and the `H_ACTIVE`/`V_ACTIVE` parameters.
  - Outputs: `x`, `y`, `last` = (`H_ACTIVE`-1, `V_ACTIVE`-1).
  - The top level holds the FSM, edge detection and output registers.

## Test plan
All scenarios use `H_ACTIVE` = 4 and `V_ACTIVE` = 2.

- **Normal frame:** `iSTART`, then an `fs` edge, then 8 valid pixels 12'h001..12'h008. Expect 8 `oDVAL` cycles with coordinates (0,0)..(3,0),(0,1)..(3,1), `oFRAME_DONE` with pixel 8, return to ARM, and `oFRAME_CNT` = 1.
- **Mid-frame arm:** `iFVAL` is already high when `iSTART` rises. Expect no `oDVAL` until the next `fs` edge. The next frame is captured fully starting at (0,0).
- **Stop mid-frame:** `iSTOP` pulses after pixel 3. Pixels 4..8 are still output, `oFRAME_DONE` pulses, then IDLE with `oBUSY` = 0. A following `fs` produces no `oDVAL`.
- **Short frame:** `iFVAL` drops after 5 pixels. Expect one `oFRAME_ERR`, no `oFRAME_DONE`, return to ARM, and `oFRAME_CNT` unchanged. The next full frame restarts at (0,0).
- **Start/stop contention:** `iSTART` and `iSTOP` are high together in IDLE → remain IDLE. In ARM, `iSTOP` coincides with `fs` → IDLE and no pixels output.
- **Reset mid-frame:** reset at pixel 6 with `iSTART` held high. All outputs are 0 during reset, and the rest of that frame is ignored. The next `fs` is captured at (0,0).
